avr_pmem: RTL

Program-memory responder for the AVR core: answers the fetch unit's word-address requests with 16-bit instruction words after a configurable number of wait states. It raises a stall while a read is in flight so the fetch unit can hold its PC. It also contains the writer side of program memory: a byte-serial loader that assembles little-endian instruction words and writes them sequentially while the core is held off.

---
 rtl/avr_pmem.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/avr_pmem.sv
// avr_pmem: program-memory responder for the AVR fetch unit plus the
// byte-serial loader that fills the array while the core is held off.
// Reads complete after WAIT extra cycles. The loader assembles
// little-endian words and writes them sequentially.
// Optional feature macro: AVR_PMEM_PARITY_EN adds an even-parity bit to each
// array word. A parity mismatch on a read sets a sticky par_err and
// delivers a NOP instead of the stored word.
module avr_pmem #(
    parameter int ADDR_W = 12,
    parameter int WAIT   = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] prog_addr,
    output logic [15:0] prog_data,
    output logic        prog_valid,
    output logic        stall,
    input  logic        ld_en,
    input  logic        ld_strobe,
    input  logic [7:0]  ld_byte,
    output logic [15:0] ld_count,
    output logic        ld_full,
    output logic        par_err
);

    localparam int DEPTH = 1 << ADDR_W;
`ifdef AVR_PMEM_PARITY_EN
    localparam int MEM_W = 17;
`else
    localparam int MEM_W = 16;
`endif
    localparam logic [2:0]      WAIT_INIT = 3'(WAIT);
    localparam logic [16:0]     DEPTH_EXT = 17'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    state_t            state;
    logic [MEM_W-1:0]  mem [0:DEPTH-1];
    logic [15:0]       addr_q;
    logic [2:0]        wcnt;
    logic [ADDR_W:0]   ptr;
    logic [ADDR_W:0]   ptr_inc;
    logic [7:0]        lo_q;
    logic              phase;
    logic              in_range;
    logic              wr_en;
    logic              rd_bad;
    logic [MEM_W-1:0]  rd_raw;
    logic [MEM_W-1:0]  wr_word;
    logic [15:0]       rd_word;

    // Even parity over one instruction word (stored bit makes total XOR zero).
    function automatic logic even_parity(input logic [15:0] d);
        return ^d;
    endfunction

    assign stall    = (prog_addr != addr_q) | ~prog_valid | ld_en;
    assign ld_count = 16'(ptr);
    assign ptr_inc  = ptr + PTR_ONE;
    assign in_range = ({1'b0, addr_q} < DEPTH_EXT);
    assign rd_raw   = mem[addr_q[ADDR_W-1:0]];
    // A write only happens on the completing byte, in LOAD, while room remains.
    assign wr_en    = (state == S_LOAD) && ld_en && ld_strobe && phase
                      && !ptr[ADDR_W] && !RST;

`ifdef AVR_PMEM_PARITY_EN
    assign wr_word = {even_parity({ld_byte, lo_q}), ld_byte, lo_q};
`else
    assign wr_word = {ld_byte, lo_q};
    assign par_err = 1'b0;
`endif

    // Select the read word; out-of-range addresses give a NOP, never an alias.
    always_comb begin
        rd_word = 16'h0000;
        rd_bad  = 1'b0;
        if (in_range) begin
            rd_word = rd_raw[15:0];
`ifdef AVR_PMEM_PARITY_EN
            rd_bad  = (rd_raw[16] != even_parity(rd_raw[15:0]));
`else
            rd_bad  = 1'b0;
`endif
        end else begin
            rd_word = 16'h0000;
            rd_bad  = 1'b0;
        end
    end

    // Array write port; contents survive RST.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[ptr[ADDR_W-1:0]] <= wr_word;
        end
    end

    // Read/load sequencer with registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            prog_data  <= 16'h0000;
            prog_valid <= 1'b0;
            addr_q     <= 16'h0000;
            wcnt       <= 3'd0;
            ptr        <= '0;
            lo_q       <= 8'h00;
            phase      <= 1'b0;
            ld_full    <= 1'b0;
`ifdef AVR_PMEM_PARITY_EN
            par_err    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (ld_en) begin
                        state      <= S_LOAD;
                        prog_valid <= 1'b0;
                        ptr        <= '0;
                        phase      <= 1'b0;
                        ld_full    <= 1'b0;
                    end else if ((prog_addr != addr_q) || !prog_valid) begin
                        addr_q     <= prog_addr;
                        wcnt       <= WAIT_INIT;
                        prog_valid <= 1'b0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ld_en) begin
                        state      <= S_LOAD;
                        prog_valid <= 1'b0;
                        ptr        <= '0;
                        phase      <= 1'b0;
                        ld_full    <= 1'b0;
                    end else if (prog_addr != addr_q) begin
                        // Fetch moved on: restart the access at the new address.
                        addr_q <= prog_addr;
                        wcnt   <= WAIT_INIT;
                    end else if (wcnt != 3'd0) begin
                        wcnt <= wcnt - 3'd1;
                    end else begin
                        prog_data  <= rd_bad ? 16'h0000 : rd_word;
                        prog_valid <= 1'b1;
                        state      <= S_IDLE;
`ifdef AVR_PMEM_PARITY_EN
                        if (rd_bad) begin
                            par_err <= 1'b1;
                        end
`endif
                    end
                end
                S_LOAD: begin
                    if (!ld_en) begin
                        // Leave with no valid data; an unpaired low byte is dropped.
                        state      <= S_IDLE;
                        prog_valid <= 1'b0;
                        phase      <= 1'b0;
                    end else if (ld_strobe) begin
                        if (!phase) begin
                            lo_q  <= ld_byte;
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (!ptr[ADDR_W]) begin
                                ptr <= ptr_inc;
                                if (ptr_inc[ADDR_W]) begin
                                    ld_full <= 1'b1;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    prog_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
